// File: rtl/ext_pkg.sv
// Shared definitions for the pipelined immediate extender: extension modes
// and the status flags carried alongside each result.
package ext_pkg;

  localparam logic [1:0] MODE_ZERO    = 2'b00;
  localparam logic [1:0] MODE_SIGN    = 2'b01;
  localparam logic [1:0] MODE_SIGN_SH = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  typedef struct packed {
    logic err;
    logic ovf;
  } ext_flags_t;

endpackage

// File: rtl/extensor_pipe_reg_stage.sv
// One valid/ready register slice. It refills in the same cycle it drains, so
// a chain of these sustains one transfer per cycle.
module pipe_reg_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/extensor_pipe.sv
// Two-stage immediate extender: stage 1 extends and flags, stage 2 applies the
// optional left shift. Keeps a saturating count of overflowing results.
module extensor_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter int SH_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [SH_W-1:0]  in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int MAX_SH = (1 << SH_W) - 1;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [SH_W-1:0]  shamt;
    ext_flags_t       flags;
  } s1_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    ext_flags_t       flags;
  } s2_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic s1_valid, s2_ready;

  // Overflow is known before the shift: the shamt bits below the sign must
  // all match it, otherwise significant bits or the sign would be lost.
  always_comb begin
    s1_d = '0;
    case (in_mode)
      MODE_ZERO: s1_d.data = OUT_W'(in_data);
      MODE_SIGN, MODE_SIGN_SH: begin
        s1_d.data = OUT_W'(in_data);
        for (int i = IN_W; i < OUT_W; i++) s1_d.data[i] = in_data[IN_W-1];
      end
      default: s1_d.flags.err = 1'b1;
    endcase
    if (in_mode == MODE_SIGN_SH) s1_d.shamt = in_shamt;
    for (int j = 1; j <= MAX_SH; j++) begin
      if (SH_W'(j) <= s1_d.shamt && s1_d.data[OUT_W-1-j] != s1_d.data[OUT_W-1])
        s1_d.flags.ovf = 1'b1;
    end
  end

  always_comb begin
    s2_d       = '0;
    s2_d.data  = s1_q.data << s1_q.shamt;
    s2_d.flags = s1_q.flags;
  end

  pipe_reg_stage #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  pipe_reg_stage #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign out_data = s2_q.data;
  assign out_ovf  = s2_q.flags.ovf;
  assign out_err  = s2_q.flags.err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (cnt_clr) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && out_ovf && ovf_count != '1) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_extensor_pipe.sv
// Directed bench for extensor_pipe with the default 3-to-8 configuration.
module tb_extensor_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic [1:0] in_mode;
  logic [2:0] in_shamt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       out_err;
  logic       cnt_clr;
  logic [7:0] ovf_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  extensor_pipe #(.IN_W(3), .OUT_W(8), .SH_W(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_err   (out_err),
    .cnt_clr   (cnt_clr),
    .ovf_count (ovf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one item and returns 1 time unit after the edge that accepted it.
  task automatic push(input logic [2:0] d, input logic [1:0] m, input logic [2:0] sh);
    bit ok = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_mode = m; in_shamt = sh;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [2:0] d, input logic [1:0] m,
                      input logic [2:0] sh, input logic [7:0] ed, input logic eo, input logic ee);
    out_ready = 1'b1;
    push(d, m, sh);
    chk({tag, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_ovf"}, out_ovf, eo);
    chk({tag, "_err"}, out_err, ee);
    @(posedge clk); #1;
  endtask

  // Holds one overflowing result at the output, then takes it with cnt_clr as given.
  task automatic take_ovf(input logic clr);
    out_ready = 1'b0;
    push(3'b011, 2'b10, 3'd7);
    @(posedge clk); #1;
    chk("hold_ovf_valid", out_valid, 1);
    @(negedge clk);
    out_ready = 1'b1; cnt_clr = clr;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  int idx_in, idx_out, acc, got;
  bit saw_full, held_valid, tk, ac;
  logic [7:0] held_data, e;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_shamt = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_ovf_count", ovf_count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    run1("sign_100", 3'b100, 2'b01, 3'd0, 8'b11111100, 0, 0);
    run1("zero_100", 3'b100, 2'b00, 3'd0, 8'b00000100, 0, 0);
    run1("zero_shforced", 3'b100, 2'b00, 3'd7, 8'b00000100, 0, 0);
    run1("sign_011", 3'b011, 2'b01, 3'd0, 8'b00000011, 0, 0);
    run1("sh_011_2", 3'b011, 2'b10, 3'd2, 8'b00001100, 0, 0);
    chk("cnt_after_sh2", ovf_count, 0);
    run1("sh_011_7", 3'b011, 2'b10, 3'd7, 8'b10000000, 1, 0);
    chk("cnt_after_sh7", ovf_count, 1);
    run1("sh_111_5", 3'b111, 2'b10, 3'd5, 8'b11100000, 0, 0);
    run1("sh_100_0", 3'b100, 2'b10, 3'd0, 8'b11111100, 0, 0);
    run1("rsvd_101", 3'b101, 2'b11, 3'd3, 8'b00000000, 0, 1);
    chk("cnt_after_rsvd", ovf_count, 1);

    // Back-pressure stream: consumer ready one cycle in three.
    idx_in = 0; idx_out = 0; saw_full = 0; held_valid = 0; held_data = '0;
    for (int cyc = 0; cyc < 200 && idx_out < 8; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      in_valid = (idx_in < 8); in_data = 3'(idx_in); in_mode = 2'b01; in_shamt = 3'd0;
      #1;
      if (held_valid) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", out_data, held_data);
      end
      if (in_valid && !in_ready) begin
        saw_full = 1;
        chk("bp_full_outvalid", out_valid, 1);
      end
      ac = in_valid && in_ready;
      tk = out_valid && out_ready;
      if (tk) begin
        e = (idx_out >= 4) ? (8'hF8 | 8'(idx_out)) : 8'(idx_out);
        chk("bp_data", out_data, e);
      end
      held_valid = out_valid && !out_ready;
      held_data = out_data;
      @(posedge clk);
      if (ac) idx_in++;
      if (tk) idx_out++;
    end
    #1; in_valid = 1'b0;
    chk("bp_count", idx_out, 8);
    chk("bp_saw_full", saw_full, 1);

    // Saturation: clear, then 260 overflowing results.
    @(negedge clk); cnt_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    chk("clr_alone", ovf_count, 0);
    acc = 0; got = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 3'b011; in_mode = 2'b10; in_shamt = 3'd7;
    for (int cyc = 0; cyc < 400 && got < 260; cyc++) begin
      #1;
      in_valid = (acc < 260);
      #1;
      ac = in_valid && in_ready;
      tk = out_valid && out_ready && out_ovf;
      @(posedge clk);
      if (ac) acc++;
      if (tk) got++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("sat_got", got, 260);
    chk("sat_count", ovf_count, 255);

    take_ovf(1'b1);
    chk("clr_vs_inc_sat", ovf_count, 0);
    take_ovf(1'b0);
    chk("inc_after_clr", ovf_count, 1);
    take_ovf(1'b1);
    chk("clr_vs_inc", ovf_count, 0);
    take_ovf(1'b0);
    chk("inc_before_rst", ovf_count, 1);

    // Reset with two items in flight.
    out_ready = 1'b0;
    push(3'b001, 2'b01, 3'd0);
    push(3'b010, 2'b01, 3'd0);
    @(negedge clk); #1;
    chk("mid_full_inready", in_ready, 0);
    chk("mid_full_outvalid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outvalid", out_valid, 0);
    chk("mid_rst_outdata", out_data, 0);
    chk("mid_rst_count", ovf_count, 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_inready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("mid_no_stale", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
